// File: rtl/pnr_pkg.sv
// Shared constants and state encoding for the PNR trigger sequencer.
package pnr_pkg;

  localparam int unsigned PNR_DW       = 14;
  localparam int unsigned PNR_CW       = 32;
  localparam int unsigned PNR_PEAK_WIN = 8;
  localparam int unsigned PNR_WIN_W    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    DELAY     = 3'd2,
    HOLDOFF   = 3'd3,
    CAPTURE   = 3'd4
  } pnr_state_e;

  // Most negative two's complement sample; the crossing detector starts here.
  localparam logic signed [PNR_DW-1:0] PNR_SAMPLE_MIN = {1'b1, {(PNR_DW-1){1'b0}}};

endpackage

// File: rtl/pnr_threshold_cross.sv
// Rising threshold-crossing detector on the trigger ADC channel.
// cross_c_o is combinational: it compares the live sample against the
// registered previous sample in the same cycle.
module pnr_threshold_cross
  import pnr_pkg::*;
#(
  parameter int unsigned DW = PNR_DW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [DW-1:0] sample_i,
  input  logic signed [DW-1:0] threshold_i,
  output logic                 cross_c_o
);

  localparam logic signed [DW-1:0] PREV_RST = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] prev_q;

  // Previous trigger sample, refreshed every cycle regardless of sequencer state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= PREV_RST;
    end else begin
      prev_q <= sample_i;
    end
  end

  assign cross_c_o = (prev_q < threshold_i) && (sample_i >= threshold_i);

endmodule

// File: rtl/pnr_trigger_sequencer.sv
// Per-event controller for the PNR datapath: detect a rising trigger crossing,
// wait pnr_delay cycles, capture the PNR channel, then hold off re-triggering
// for trig_clearance cycles.
// Optional feature macro: PNR_PEAK_EN -- capture becomes the signed maximum
// over a PEAK_WIN-cycle window starting at the capture cycle.
module pnr_trigger_sequencer
  import pnr_pkg::*;
#(
  parameter int unsigned DW       = PNR_DW,
  parameter int unsigned CW       = PNR_CW,
  parameter int unsigned PEAK_WIN = PNR_PEAK_WIN
) (
  input  logic                 ADC_CLK,
  input  logic                 ADC_RST,
  input  logic                 enable,
  input  logic signed [DW-1:0] trig_source_sig,
  input  logic signed [DW-1:0] pnr_source_sig,
  input  logic signed [DW-1:0] trig_threshold,
  input  logic [CW-1:0]        trig_clearance,
  input  logic [CW-1:0]        pnr_delay,
  output logic                 trig_pulse,
  output logic                 sample_strobe,
  output logic signed [DW-1:0] pnr_value,
  output logic                 pnr_valid,
  output logic                 busy,
  output logic [CW-1:0]        trig_count
);

  pnr_state_e           state_q;
  logic [CW-1:0]        dly_q;
  logic [CW-1:0]        clr_q;
  logic [CW-1:0]        dcnt_q;
  logic [CW-1:0]        ccnt_q;
  logic [CW-1:0]        trig_count_q;
  logic signed [DW-1:0] pnr_value_q;
  logic                 trig_pulse_q;
  logic                 sample_strobe_q;
  logic                 pnr_valid_q;
  logic                 busy_q;

  logic cross_c;
  logic dly_done_c;
  logic clr_done_c;
  logic cap_now_c;
  logic cap_clr_done_c;

  pnr_threshold_cross #(
    .DW (DW)
  ) u_cross (
    .clk_i       (ADC_CLK),
    .rst_i       (ADC_RST),
    .sample_i    (trig_source_sig),
    .threshold_i (trig_threshold),
    .cross_c_o   (cross_c)
  );

  // dcnt_q/ccnt_q hold cycles elapsed since the trigger cycle (0 at the trigger
  // itself) and stop at the latched value, so equality is the done test and
  // the counters never wrap even for 2^CW-1.
  assign dly_done_c = (dcnt_q == dly_q);
  assign clr_done_c = (ccnt_q == clr_q);

  // Capture cycle: the trigger cycle itself for zero delay, else end of DELAY.
  assign cap_now_c = ((state_q == WAIT_TRIG) && cross_c && (pnr_delay == '0)) ||
                     ((state_q == DELAY) && dly_done_c);

  // Clearance status as of the capture cycle; at the trigger cycle only a
  // zero clearance counts as already elapsed.
  assign cap_clr_done_c = (state_q == WAIT_TRIG) ? (trig_clearance == '0) : clr_done_c;

`ifdef PNR_PEAK_EN
  localparam logic [PNR_WIN_W-1:0] WIN_LAST = PNR_WIN_W'(PEAK_WIN - 1);

  logic signed [DW-1:0] peak_q;
  logic [PNR_WIN_W-1:0] wcnt_q;
  logic signed [DW-1:0] peak_nxt_c;

  assign peak_nxt_c = (pnr_source_sig > peak_q) ? pnr_source_sig : peak_q;
`else
  // PEAK_WIN only shapes the peak window, which is absent in this build.
  logic unused_peak_win;
  assign unused_peak_win = ^PEAK_WIN;
`endif

  // Sequencer FSM, per-event counters and registered outputs.
  always_ff @(posedge ADC_CLK) begin
    if (ADC_RST) begin
      state_q         <= IDLE;
      dly_q           <= '0;
      clr_q           <= '0;
      dcnt_q          <= '0;
      ccnt_q          <= '0;
      trig_count_q    <= '0;
      pnr_value_q     <= '0;
      trig_pulse_q    <= 1'b0;
      sample_strobe_q <= 1'b0;
      pnr_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
`ifdef PNR_PEAK_EN
      peak_q          <= '0;
      wcnt_q          <= '0;
`endif
    end else begin
      trig_pulse_q    <= 1'b0;
      sample_strobe_q <= 1'b0;
      pnr_valid_q     <= 1'b0;
      if (!enable) begin
        // Disarm: any pending capture is dropped, count and value are kept.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= WAIT_TRIG;
            busy_q  <= 1'b0;
          end
          WAIT_TRIG: begin
            if (cross_c) begin
              trig_pulse_q <= 1'b1;
              trig_count_q <= trig_count_q + CW'(1);
              dly_q        <= pnr_delay;
              clr_q        <= trig_clearance;
              dcnt_q       <= CW'(1);
              ccnt_q       <= (trig_clearance != '0) ? CW'(1) : '0;
              state_q      <= DELAY;
              busy_q       <= 1'b1;
            end
          end
          DELAY: begin
            if (!clr_done_c) ccnt_q <= ccnt_q + CW'(1);
            if (!dly_done_c) dcnt_q <= dcnt_q + CW'(1);
          end
`ifdef PNR_PEAK_EN
          CAPTURE: begin
            if (!clr_done_c) ccnt_q <= ccnt_q + CW'(1);
            if (wcnt_q == WIN_LAST) begin
              pnr_value_q <= peak_nxt_c;
              pnr_valid_q <= 1'b1;
              state_q     <= clr_done_c ? WAIT_TRIG : HOLDOFF;
              busy_q      <= !clr_done_c;
            end else begin
              peak_q <= peak_nxt_c;
              wcnt_q <= wcnt_q + PNR_WIN_W'(1);
            end
          end
`endif
          HOLDOFF: begin
            if (clr_done_c) begin
              state_q <= WAIT_TRIG;
              busy_q  <= 1'b0;
            end else begin
              ccnt_q <= ccnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase

        // Capture overrides the state update made above in the same cycle.
        if (cap_now_c) begin
          sample_strobe_q <= 1'b1;
`ifdef PNR_PEAK_EN
          if (WIN_LAST == '0) begin
            pnr_value_q <= pnr_source_sig;
            pnr_valid_q <= 1'b1;
            state_q     <= cap_clr_done_c ? WAIT_TRIG : HOLDOFF;
            busy_q      <= !cap_clr_done_c;
          end else begin
            peak_q  <= pnr_source_sig;
            wcnt_q  <= PNR_WIN_W'(1);
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
          end
`else
          pnr_value_q <= pnr_source_sig;
          pnr_valid_q <= 1'b1;
          state_q     <= cap_clr_done_c ? WAIT_TRIG : HOLDOFF;
          busy_q      <= !cap_clr_done_c;
`endif
        end
      end
    end
  end

  assign trig_pulse    = trig_pulse_q;
  assign sample_strobe = sample_strobe_q;
  assign pnr_value     = pnr_value_q;
  assign pnr_valid     = pnr_valid_q;
  assign busy          = busy_q;
  assign trig_count    = trig_count_q;

endmodule

// File: tb/tb_pnr_trigger_sequencer.sv
// Scoreboard bench for pnr_trigger_sequencer. Stimulus pushes expected
// trig_pulse / sample_strobe / pnr_valid events; a negedge monitor pops them.
// The PNR channel is driven with the cycle number, so a single-sample capture
// returns the capture cycle and a peak window returns its last cycle.
module tb_pnr_trigger_sequencer;

  localparam int unsigned DW = 14;
  localparam int unsigned CW = 32;
  localparam int unsigned PW = 4;
`ifdef PNR_PEAK_EN
  localparam int EXTRA = PW - 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic signed [DW-1:0] HI  = 14'sd150;
  localparam logic signed [DW-1:0] LO  = -14'sd50;
  localparam logic signed [DW-1:0] THR = 14'sd100;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic signed [DW-1:0] trig;
  logic signed [DW-1:0] pnr;
  logic signed [DW-1:0] thr;
  logic [CW-1:0]        clr;
  logic [CW-1:0]        dly;
  logic                 trig_pulse;
  logic                 sample_strobe;
  logic signed [DW-1:0] pnr_value;
  logic                 pnr_valid;
  logic                 busy;
  logic [CW-1:0]        trig_count;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int last_val = 0;

  exp_t trig_q[$];
  exp_t val_q[$];
  int   strb_q[$];

  pnr_trigger_sequencer #(
    .DW       (DW),
    .CW       (CW),
    .PEAK_WIN (PW)
  ) dut (
    .ADC_CLK         (clk),
    .ADC_RST         (rst),
    .enable          (enable),
    .trig_source_sig (trig),
    .pnr_source_sig  (pnr),
    .trig_threshold  (thr),
    .trig_clearance  (clr),
    .pnr_delay       (dly),
    .trig_pulse      (trig_pulse),
    .sample_strobe   (sample_strobe),
    .pnr_value       (pnr_value),
    .pnr_valid       (pnr_valid),
    .busy            (busy),
    .trig_count      (trig_count)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s asserted with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pnr = DW'(cyc);
  endtask

  task automatic push_trig(input int t);
    exp_t e;
    exp_count++;
    e.cyc = t + 1;
    e.val = exp_count;
    trig_q.push_back(e);
  endtask

  task automatic push_cap(input int t, input int d, input int v);
    exp_t e;
    strb_q.push_back(t + d + 1);
    e.cyc = t + d + 1 + EXTRA;
    e.val = v;
    val_q.push_back(e);
    last_val = v;
  endtask

  task automatic cross_run(input int len, input int a, input int b, input int c);
    for (int k = 0; k < len; k++) begin
      trig = (k == a || k == b || k == c) ? HI : LO;
      tick();
    end
  endtask

  // Monitor: every output pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (trig_pulse === 1'b1) begin
      if (trig_q.size() == 0) unexpected("trig_pulse");
      else begin
        e = trig_q.pop_front();
        chk("trig_cycle", cyc, e.cyc);
        chk("trig_count", int'(trig_count), e.val);
      end
    end
    if (sample_strobe === 1'b1) begin
      if (strb_q.size() == 0) unexpected("sample_strobe");
      else chk("strobe_cycle", cyc, strb_q.pop_front());
    end
    if (pnr_valid === 1'b1) begin
      if (val_q.size() == 0) unexpected("pnr_valid");
      else begin
        e = val_q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("pnr_value", int'(pnr_value), e.val);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int s;
    rst    = 1'b1;
    enable = 1'b0;
    trig   = LO;
    pnr    = '0;
    thr    = THR;
    dly    = 32'd5;
    clr    = 32'd20;
    repeat (3) tick();

    // Reset state
    chk("rst_trig_pulse", int'(trig_pulse), 0);
    chk("rst_strobe", int'(sample_strobe), 0);
    chk("rst_pnr_value", int'(pnr_value), 0);
    chk("rst_pnr_valid", int'(pnr_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_trig_count", int'(trig_count), 0);

    rst    = 1'b0;
    enable = 1'b1;
    repeat (3) tick();

    // Basic event, then level held above threshold: no retrigger
    t = cyc;
    push_trig(t);
    push_cap(t, 5, t + 5 + EXTRA);
    for (int k = 0; k < 30; k++) begin
      trig = (k < 25) ? HI : LO;
      if (k == 1)  chk("busy_in_delay", int'(busy), 1);
      if (k == 22) chk("busy_after_clear", int'(busy), 0);
      tick();
    end

    // Zero delay captures the trigger-cycle sample
    dly = 32'd0;
    clr = 32'd3;
    t = cyc;
    push_trig(t);
    push_cap(t, 0, 1234);
    for (int k = 0; k < 10; k++) begin
      trig = (k == 0) ? HI : LO;
      if (k == 0) pnr = 14'sd1234;
      tick();
    end

    // Clearance longer than delay: crossing at +10 ignored, +21 accepted
    dly = 32'd5;
    clr = 32'd20;
    t = cyc;
    push_trig(t);
    push_cap(t, 5, t + 5 + EXTRA);
    push_trig(t + 21);
    push_cap(t + 21, 5, t + 26 + EXTRA);
    cross_run(50, 0, 10, 21);

    // Delay longer than clearance: crossing at +15 ignored, first free cycle accepted
    dly = 32'd30;
    clr = 32'd10;
    t = cyc;
    s = t + 31 + EXTRA;
    push_trig(t);
    push_cap(t, 30, t + 30 + EXTRA);
    push_trig(s);
    push_cap(s, 30, s + 30 + EXTRA);
    cross_run(70, 0, 15, 31 + EXTRA);

    // Abort by enable, crossing on the IDLE->WAIT_TRIG cycle ignored, re-arm
    dly = 32'd5;
    clr = 32'd20;
    t = cyc;
    push_trig(t);
    for (int k = 0; k < 32; k++) begin
      enable = !(k == 3 || k == 4);
      trig   = (k == 0 || k == 5 || k == 7) ? HI : LO;
      if (k == 4) begin
        chk("abort_busy", int'(busy), 0);
        chk("abort_count_held", int'(trig_count), exp_count);
        chk("abort_value_held", int'(pnr_value), last_val);
      end
      if (k == 7) begin
        push_trig(t + 7);
        push_cap(t + 7, 5, t + 12 + EXTRA);
      end
      tick();
    end

`ifdef PNR_PEAK_EN
    // Peak window over 10, 40, 25, 30
    dly = 32'd2;
    clr = 32'd0;
    t = cyc;
    push_trig(t);
    push_cap(t, 2, 40);
    for (int k = 0; k < 12; k++) begin
      trig = (k == 0) ? HI : LO;
      pnr  = (k == 2) ? 14'sd10 : (k == 3) ? 14'sd40 : (k == 4) ? 14'sd25 :
             (k == 5) ? 14'sd30 : -14'sd100;
      tick();
    end
    dly = 32'd5;
    clr = 32'd20;
`endif

    // Reset in the middle of an event: no capture, everything cleared
    t = cyc;
    push_trig(t);
    for (int k = 0; k < 10; k++) begin
      trig = (k == 0) ? HI : LO;
      rst  = (k == 2 || k == 3);
      if (k == 4) begin
        chk("midrst_count", int'(trig_count), 0);
        chk("midrst_value", int'(pnr_value), 0);
        chk("midrst_busy", int'(busy), 0);
      end
      tick();
    end
    exp_count = 0;

    // Counter restarts from one after reset
    t = cyc;
    push_trig(t);
    push_cap(t, 5, t + 5 + EXTRA);
    cross_run(40, 0, -1, -1);

    repeat (5) tick();
    chk("trig_q_drained", trig_q.size(), 0);
    chk("strb_q_drained", strb_q.size(), 0);
    chk("val_q_drained", val_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pnr_trigger_sequencer.md
Name: pnr_trigger_sequencer

Overview:
- Per-event controller for the photon-number-resolving (PNR) datapath.
- Watches the trigger ADC channel for a rising threshold crossing, waits a programmable delay, then captures one sample of the PNR ADC channel.
- After each trigger, suppresses re-triggering for a programmable clearance time.
- Sits between the ADC inputs / config registers and the downstream PNR classifier / GPIO drivers inside the PNR top level.

Parameters:
- DW, 14: ADC sample width; samples and threshold are two's complement.
- CW, 32: width of the delay and clearance config words and of the event counter.
- PEAK_WIN, 8: window length in cycles for peak capture; used only with PNR_PEAK_EN. Legal range is 1..255.

Ports:
- ADC_CLK  in  1  sole clock (125 MHz ADC clock).
- ADC_RST  in  1  synchronous, active-high reset.
- enable  in  1  arms the sequencer; low forces IDLE.
- trig_source_sig  in  DW  trigger channel sample, signed.
- pnr_source_sig  in  DW  PNR channel sample, signed.
- trig_threshold  in  DW  signed trigger level.
- trig_clearance  in  CW  cycles after a trigger during which crossings are ignored.
- pnr_delay  in  CW  cycles from trigger to PNR capture.
- trig_pulse  out  1  one-cycle pulse on an accepted trigger.
- sample_strobe  out  1  one-cycle pulse on the capture cycle.
- pnr_value  out  DW  captured PNR sample, held until the next capture.
- pnr_valid  out  1  one-cycle pulse; pnr_value is new.
- busy  out  1  high in DELAY or HOLDOFF.
- trig_count  out  CW  number of accepted triggers; wraps modulo 2^CW.

Behaviour:
- Reset values: all outputs 0; state IDLE; the prev-sample register is loaded with the most negative value (-2^(DW-1)).
- Crossing detection:
  - Registered previous trigger sample prev.
  - cross = (prev < trig_threshold) && (trig_source_sig >= trig_threshold), signed compare.
  - prev updates every cycle in every state.
- States: IDLE, WAIT_TRIG, DELAY, HOLDOFF.
- IDLE -> WAIT_TRIG when enable=1.
- WAIT_TRIG, on cross at cycle T:
  - trig_pulse=1 in cycle T+1.
  - trig_count increments (visible at T+1).
  - trig_clearance and pnr_delay are latched at T and stay stable for the whole event.
  - Delay counter and clearance counter both start at 0.
- If the latched delay is 0: pnr_source_sig is captured at T, sample_strobe=1 and pnr_valid=1 at T+1, then go to HOLDOFF.
- Otherwise go to DELAY.
- DELAY:
  - pnr_source_sig is captured in cycle T+pnr_delay.
  - sample_strobe and pnr_valid pulse at T+pnr_delay+1.
  - Then go to HOLDOFF.
- HOLDOFF: return to WAIT_TRIG in the first cycle in which the capture is done and at least trig_clearance cycles have passed since T.
- Next trigger window:
  - The earliest acceptable next crossing is cycle T + max(trig_clearance, pnr_delay) + 1.
  - Crossings in DELAY or HOLDOFF are ignored and are not counted.
- Config changes during DELAY or HOLDOFF have no effect until the next trigger.
- Boundary conditions:
  - enable low in any state: next cycle IDLE; a pending capture is aborted (no pnr_valid); trig_count and pnr_value are held.
  - A crossing in the same cycle as the IDLE->WAIT_TRIG transition is not accepted.
  - A crossing in the cycle WAIT_TRIG is re-entered is accepted.
  - Delay and clearance values up to 2^CW-1 must work with no counter overflow; compare with equality on a counter that never passes the latched value.
  - ADC_RST has priority over everything.
  - Reset mid-event clears everything to the reset values; no pnr_valid is emitted.

Optional Feature:
- PNR_PEAK_EN defined: capture becomes a window.
  - Starting at the capture cycle, track the signed maximum of pnr_source_sig over PEAK_WIN consecutive cycles.
  - sample_strobe still fires at T+pnr_delay+1.
  - pnr_valid and the new pnr_value arrive at T+pnr_delay+PEAK_WIN.
  - HOLDOFF exit also requires the window to be done.
  - Adds state CAPTURE between DELAY and HOLDOFF.
- PNR_PEAK_EN undefined: single-sample capture as above; PEAK_WIN is ignored.

Decomposition:
- Shared package pnr_pkg holds:
  - DW/CW constants;
  - the state enum (IDLE=0, WAIT_TRIG=1, DELAY=2, HOLDOFF=3, CAPTURE=4);
  - the most-negative-sample constant.
- One natural sub-module: pnr_threshold_cross. It holds the prev register and the signed compare, and outputs cross.

Test Plan:
- Reset behaviour: threshold=100, delay=5, clearance=20, enable=1; trigger ramps -50 -> 150 at cycle T -> trig_pulse at T+1; pnr_source captured at T+5; pnr_valid at T+6 with that value; trig_count=1.
- Delay 0: delay=0, pnr_source=1234 at T -> pnr_valid at T+1 with pnr_value=1234.
- Clearance: clearance=20, delay=5, crossings at T+10 and T+21 -> the first is ignored, the second is accepted; trig_count=2.
- Delay longer than clearance: delay=30, clearance=10, crossing at T+15 -> ignored; a crossing at T+31 is accepted.
- Abort: enable drops at T+3 with delay=5 -> no pnr_valid; pnr_value unchanged; IDLE one cycle later; reasserting enable re-arms.
- Level held above threshold with no new rising edge -> no retrigger; with PNR_PEAK_EN and PEAK_WIN=4 on samples 10, 40, 25, 30 -> pnr_value=40 at T+delay+4.
